// File: rtl/ghost_map_rd_arbiter.sv
// ghost_map_rd_arbiter: round-robin share of the ghost map RAM read port with fixed-latency tagged responses
module ghost_map_rd_arbiter #(
  parameter int NREQ   = 4,
  parameter int RD_LAT = 1,
  parameter int MAP_W  = 40,
  parameter int MAP_H  = 30
) (
  input  logic              CLOCK_50,
  input  logic              reset,
  input  logic              map_ready,
  input  logic [NREQ-1:0]   req,
  input  logic [6*NREQ-1:0] req_x,
  input  logic [5*NREQ-1:0] req_y,
  output logic [NREQ-1:0]   gnt,
  output logic [5:0]        rdaddr_x,
  output logic [4:0]        rdaddr_y,
  input  logic [7:0]        data,
  output logic [NREQ-1:0]   rsp_valid,
  output logic [7:0]        rsp_data,
  output logic              rsp_stale,
  output logic              busy
);
  localparam int PW = $clog2(NREQ);
  localparam int D = RD_LAT + 1;
  localparam logic [NREQ-1:0] one_hot0 = NREQ'(1);
  logic [NREQ-1:0] elig;
  logic [PW-1:0] rr_ptr, win;
  logic [PW:0] s;
  logic found, woob;
  logic [5:0] wx;
  logic [4:0] wy;
  logic [D-1:0] pv, po, ps;
  logic [PW-1:0] pw [D];
  always_comb begin
    elig = req & ~gnt & {NREQ{map_ready}};
    found = |elig;
    win = '0;
    s = '0;
    for (int j = NREQ - 1; j >= 0; j--) begin
      s = {1'b0, rr_ptr} + (PW+1)'(j);
      s = s >= (PW+1)'(NREQ) ? s - (PW+1)'(NREQ) : s;
      win = elig[s[PW-1:0]] ? s[PW-1:0] : win;
    end
    wx = req_x[6*win +: 6];
    wy = req_y[5*win +: 5];
    woob = int'(wx) >= MAP_W || int'(wy) >= MAP_H;
  end
  // tags shift one stage per cycle; stale accumulates any cycle spent with map_ready low
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      gnt <= '0;
      rr_ptr <= '0;
      rdaddr_x <= '0;
      rdaddr_y <= '0;
      rsp_valid <= '0;
      rsp_data <= '0;
      rsp_stale <= 1'b0;
      pv <= '0;
      po <= '0;
      ps <= '0;
      for (int k = 0; k < D; k++) pw[k] <= '0;
    end else begin
      gnt <= found ? one_hot0 << win : '0;
      if (found) begin
        rr_ptr <= win == PW'(NREQ - 1) ? '0 : win + 1'b1;
        rdaddr_x <= wx;
        rdaddr_y <= wy;
      end
      pv <= {pv[D-2:0], found};
      po <= {po[D-2:0], woob};
      ps <= {ps[D-2:0] | {(D-1){~map_ready}}, 1'b0};
      pw[0] <= win;
      for (int k = 1; k < D; k++) pw[k] <= pw[k-1];
      rsp_valid <= pv[D-1] ? one_hot0 << pw[D-1] : '0;
      if (pv[D-1]) begin
        rsp_data <= po[D-1] ? 8'hFF : data;
        rsp_stale <= ps[D-1] | ~map_ready;
      end
    end
  end
  assign busy = |pv;
endmodule
